// File: rtl/boseben_pkg.sv
// Shared definitions for the boseben cache / backing-memory pair.
package boseben_pkg;

    localparam int MEM_DATA_W  = 32;
    localparam int MEM_ADDR_W  = 32;
    localparam int MEM_LATENCY = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } mem_state_t;

    typedef struct packed {
        logic                  we;
        logic [MEM_ADDR_W-1:0] addr;
        logic [MEM_DATA_W-1:0] wdata;
    } mem_req_t;

endpackage

// File: rtl/boseben_mem_array.sv
// Synchronous single-port word RAM with a registered, reset-able read port.
module boseben_mem_array #(
    parameter int                DATA_W       = 32,
    parameter int                DEPTH_LOG2   = 10,
    parameter logic [DATA_W-1:0] INIT_PATTERN = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we,
    input  logic                  re,
    input  logic [DEPTH_LOG2-1:0] idx,
    input  logic [DATA_W-1:0]     wdata,
    output logic [DATA_W-1:0]     rdata
);

    // Contents are never reset; the declaration value gives a known power-up image.
    logic [DATA_W-1:0] mem [2**DEPTH_LOG2] = '{default: INIT_PATTERN};

    // Array write port.
    always_ff @(posedge clk) begin
        if (we) mem[idx] <= wdata;
    end

    // Read register only updates on a read, so data holds until the next read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)  rdata <= '0;
        else if (re) rdata <= mem[idx];
    end

endmodule

// File: rtl/boseben_mem_ctrl.sv
// Backing-memory controller: one outstanding request, fixed latency, done pulse.
module boseben_mem_ctrl
    import boseben_pkg::*;
#(
    parameter int                DATA_W       = MEM_DATA_W,
    parameter int                DEPTH_LOG2   = 10,
    parameter int                LATENCY      = MEM_LATENCY,
    parameter logic [DATA_W-1:0] INIT_PATTERN = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_req_valid,
    output logic              mem_req_ready,
    input  logic              mem_we,
    input  logic [31:0]       mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic              mem_rvalid,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_wack,
    output logic              mem_busy
);

    mem_state_t            state_q, state_d;
    mem_req_t              req_q;
    logic [7:0]            cnt_q;
    logic                  accept, commit;
    logic [DEPTH_LOG2-1:0] idx;
    logic                  unused_addr;

    // Only the word index of the captured address reaches the array.
    assign idx         = req_q.addr[DEPTH_LOG2+1:2];
    assign unused_addr = ^{req_q.addr[MEM_ADDR_W-1:DEPTH_LOG2+2], req_q.addr[1:0]};

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next state: RESP accepts a new request exactly like IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (mem_req_valid) state_d = BUSY;
            BUSY:    if (cnt_q == 8'd0) state_d = RESP;
            RESP:    state_d = mem_req_valid ? BUSY : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Handshake and internal strobes decoded from the state.
    always_comb begin
        mem_req_ready = (state_q != BUSY);
        mem_busy      = (state_q == BUSY);
        accept        = mem_req_ready && mem_req_valid;
        commit        = mem_busy && (cnt_q == 8'd0);
    end

    // Request capture and latency countdown; LATENCY-2 because acceptance and
    // the response cycle each account for one edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q <= '0;
            cnt_q <= 8'd0;
        end else if (accept) begin
            req_q <= '{we: mem_we, addr: mem_addr, wdata: mem_wdata};
            cnt_q <= 8'(LATENCY - 2);
        end else if (mem_busy && cnt_q != 8'd0) begin
            cnt_q <= cnt_q - 8'd1;
        end
    end

    // Completion pulses land in the RESP cycle, after the array has committed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_rvalid <= 1'b0;
            mem_wack   <= 1'b0;
        end else begin
            mem_rvalid <= commit && !req_q.we;
            mem_wack   <= commit &&  req_q.we;
        end
    end

    boseben_mem_array #(
        .DATA_W      (DATA_W),
        .DEPTH_LOG2  (DEPTH_LOG2),
        .INIT_PATTERN(INIT_PATTERN)
    ) u_array (
        .clk  (clk),
        .rst_n(rst_n),
        .we   (commit &&  req_q.we),
        .re   (commit && !req_q.we),
        .idx  (idx),
        .wdata(req_q.wdata),
        .rdata(mem_rdata)
    );

endmodule

// File: tb/tb_boseben_mem_ctrl.sv
// Directed bench: DUT 0 at LATENCY=8 with a scoreboard, DUTs 1/2 at LATENCY=2/255.
module tb_boseben_mem_ctrl;

    localparam int LAT0 = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        v   [3];
    logic        rdy [3];
    logic        we  [3];
    logic [31:0] ad  [3];
    logic [31:0] wd  [3];
    logic        rv  [3];
    logic [31:0] rd  [3];
    logic        wk  [3];
    logic        bs  [3];

    int checks = 0;
    int errors = 0;
    int e = 0;

    typedef struct {
        logic        we;
        int          idx;
        logic [31:0] data;
        int          due;
    } ent_t;

    ent_t        q[$];
    ent_t        ent;
    logic [31:0] model [1024];
    logic [31:0] exp_rdata = 32'h0;

    always #5 clk = ~clk;
    always @(posedge clk) e <= e + 1;

    for (genvar k = 0; k < 3; k++) begin : g_dut
        localparam int LAT = (k == 0) ? LAT0 : (k == 1) ? 2 : 255;
        boseben_mem_ctrl #(.LATENCY(LAT)) u_dut (
            .clk          (clk),
            .rst_n        (rst_n),
            .mem_req_valid(v[k]),
            .mem_req_ready(rdy[k]),
            .mem_we       (we[k]),
            .mem_addr     (ad[k]),
            .mem_wdata    (wd[k]),
            .mem_rvalid   (rv[k]),
            .mem_rdata    (rd[k]),
            .mem_wack     (wk[k]),
            .mem_busy     (bs[k])
        );
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Scoreboard monitor for DUT 0. A pulse visible between edges E and E+1
    // is the one sampled at edge E+1, so an entry is due when due == e+1.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("pulse_exclusive", {31'h0, rv[0] & wk[0]}, 32'h0);
            if (q.size() != 0 && q[0].due == e + 1) begin
                ent = q.pop_front();
                chk("rvalid_on_time", {31'h0, rv[0]}, {31'h0, !ent.we});
                chk("wack_on_time", {31'h0, wk[0]}, {31'h0, ent.we});
                if (ent.we) model[ent.idx] = ent.data;
                else begin
                    chk("rdata", rd[0], ent.data);
                    exp_rdata = ent.data;
                end
            end else begin
                chk("no_rvalid", {31'h0, rv[0]}, 32'h0);
                chk("no_wack", {31'h0, wk[0]}, 32'h0);
                chk("rdata_hold", rd[0], exp_rdata);
            end
        end
    end

    // Present a request on DUT k and wait (bounded) for the accepting edge.
    task automatic issue(input int k, input logic w, input logic [31:0] a,
                         input logic [31:0] d, input bit hold);
        int   n = 0;
        bit   got = 0;
        logic s;
        ent_t x;
        v[k] = 1'b1; we[k] = w; ad[k] = a; wd[k] = d;
        while (!got && n < 600) begin
            s = rdy[k];
            @(posedge clk); #1;
            n++;
            if (s) got = 1;
        end
        chk("accepted", {31'h0, got}, 32'h1);
        if (!hold) v[k] = 1'b0;
        chk("ready_low_after_accept", {31'h0, rdy[k]}, 32'h0);
        chk("busy_after_accept", {31'h0, bs[k]}, 32'h1);
        if (k == 0) begin
            x.we   = w;
            x.idx  = int'(a[11:2]);
            x.data = w ? d : model[a[11:2]];
            x.due  = e + LAT0;
            q.push_back(x);
        end
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain", q.size(), 32'h0);
    endtask

    task automatic do_reset(input int cycles);
        rst_n = 1'b0;
        q.delete();
        exp_rdata = 32'h0;
        repeat (cycles) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Follow DUT k after acceptance: count busy samples and find the pulse.
    task automatic wait_pulse(input int k, input bit is_wr, output int pe, output int busy_n);
        int n = 0;
        pe = -1;
        busy_n = 0;
        while (pe < 0 && n < 600) begin
            if (bs[k]) busy_n++;
            if (is_wr ? wk[k] : rv[k]) pe = e;
            else begin
                @(posedge clk); #1;
                n++;
            end
        end
    endtask

    task automatic sweep(input int k, input int lat, input logic [31:0] d);
        int t0, pe, bn;
        issue(k, 1'b1, 32'h0000_0024, d, 0);
        t0 = e;
        wait_pulse(k, 1'b1, pe, bn);
        chk("sweep_wack_edge", pe, t0 + lat - 1);
        chk("sweep_busy_cycles", bn, lat - 1);
        @(posedge clk); #1;
        issue(k, 1'b0, 32'h0000_0024, 32'h0, 0);
        t0 = e;
        wait_pulse(k, 1'b0, pe, bn);
        chk("sweep_rvalid_edge", pe, t0 + lat - 1);
        chk("sweep_rdata", rd[k], d);
        @(posedge clk); #1;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) model[i] = 32'h0;
        for (int k = 0; k < 3; k++) begin
            v[k] = 1'b0; we[k] = 1'b0; ad[k] = 32'h0; wd[k] = 32'h0;
        end

        // Reset and idle
        do_reset(3);
        chk("rst_ready", {31'h0, rdy[0]}, 32'h1);
        chk("rst_busy", {31'h0, bs[0]}, 32'h0);
        chk("rst_rvalid", {31'h0, rv[0]}, 32'h0);
        chk("rst_wack", {31'h0, wk[0]}, 32'h0);
        chk("rst_rdata", rd[0], 32'h0);
        repeat (20) @(posedge clk);
        #1;

        // Write then read the same address
        issue(0, 1'b1, 32'h0000_0104, 32'hA5A5_1234, 0);
        drain();
        issue(0, 1'b0, 32'h0000_0104, 32'h0, 0);
        drain();
        chk("wr_rd_data", rd[0], 32'hA5A5_1234);

        // Aliasing of upper bits and byte-offset bits
        issue(0, 1'b1, 32'h0000_0010, 32'h1111_2222, 0);
        drain();
        issue(0, 1'b0, 32'hFFFF_F010, 32'h0, 0);
        drain();
        chk("alias_hi", rd[0], 32'h1111_2222);
        issue(0, 1'b0, 32'h0000_0013, 32'h0, 0);
        drain();
        chk("alias_lo", rd[0], 32'h1111_2222);

        // Back-to-back with valid held high, index 5
        issue(0, 1'b1, 32'h0000_0014, 32'h5555_0001, 1);
        issue(0, 1'b0, 32'h0000_0014, 32'h0, 1);
        issue(0, 1'b1, 32'h0000_0014, 32'h5555_0002, 0);
        drain();
        issue(0, 1'b0, 32'h0000_0014, 32'h0, 0);
        drain();
        chk("b2b_final", rd[0], 32'h5555_0002);

        // Reset mid-write to index 7
        issue(0, 1'b1, 32'h0000_001C, 32'h0000_0007, 0);
        drain();
        begin
            int t0;
            issue(0, 1'b1, 32'h0000_001C, 32'hDEAD_BEEF, 0);
            t0 = e;
            while (e < t0 + 4) begin @(posedge clk); #1; end
            do_reset(2);
        end
        chk("abort_idle_ready", {31'h0, rdy[0]}, 32'h1);
        chk("abort_rdata_rst", rd[0], 32'h0);
        repeat (12) @(posedge clk);
        #1;
        issue(0, 1'b0, 32'h0000_001C, 32'h0, 0);
        drain();
        chk("abort_keeps_old", rd[0], 32'h0000_0007);

        // Latency extremes
        sweep(1, 2, 32'hC0DE_0002);
        sweep(2, 255, 32'hC0DE_00FF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
